// File: rtl/prog_load_ctrl.sv
// Program-load front end: debounces the program button into single memory writes at an
// auto-incrementing address, and sequences the CPU reset when switching to run mode.
module prog_load_ctrl #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned RST_CYCLES = 3
) (
  input  logic              clock,
  input  logic              reset_N,
  input  logic              mode,
  input  logic              p_clock,
  input  logic [7:0]        io_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset_N,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic [1:0]        state_led
);

  localparam int unsigned DbW = $clog2(DEBOUNCE + 1);
  localparam int unsigned RcW = $clog2(RST_CYCLES + 1);
  localparam logic [ADDR_W:0] LastCount = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [1:0] {
    StProg  = 2'b00,
    StWrite = 2'b01,
    StStart = 2'b10,
    StRun   = 2'b11
  } state_e;

  state_e         state_q;
  logic           mode_s1_q, mode_s2_q;
  logic           pc_s1_q, pc_s2_q;
  logic           stable_q;
  logic           press_q;
  logic [DbW-1:0] db_cnt_q;
  logic [RcW-1:0] rst_cnt_q;

  assign state_led = state_q;

  always_ff @(posedge clock) begin
    if (!reset_N) begin
      state_q     <= StProg;
      mode_s1_q   <= 1'b1;
      mode_s2_q   <= 1'b1;
      pc_s1_q     <= 1'b1;
      pc_s2_q     <= 1'b1;
      stable_q    <= 1'b1;
      press_q     <= 1'b0;
      db_cnt_q    <= '0;
      rst_cnt_q   <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 8'h00;
      cpu_reset_N <= 1'b0;
      word_count  <= '0;
      full        <= 1'b0;
    end else begin
      mode_s1_q <= mode;
      mode_s2_q <= mode_s1_q;
      pc_s1_q   <= p_clock;
      pc_s2_q   <= pc_s1_q;

      // Press is registered so the FSM acts one edge after the stable level falls.
      press_q <= 1'b0;
      if (pc_s2_q != stable_q) begin
        if (db_cnt_q == DbW'(DEBOUNCE - 1)) begin
          stable_q <= pc_s2_q;
          db_cnt_q <= '0;
          press_q  <= stable_q;
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end
      end else begin
        db_cnt_q <= '0;
      end

      mem_we <= 1'b0;
      unique case (state_q)
        StProg: begin
          if (!mode_s2_q) begin
            state_q   <= StStart;
            rst_cnt_q <= '0;
          end else if (press_q && !full) begin
            state_q   <= StWrite;
            mem_we    <= 1'b1;
            mem_wdata <= io_in;
          end
        end
        StWrite: begin
          mem_addr   <= mem_addr + 1'b1;
          word_count <= word_count + 1'b1;
          full       <= (word_count == LastCount);
          state_q    <= StProg;
        end
        StStart: begin
          if (mode_s2_q) begin
            state_q    <= StProg;
            mem_addr   <= '0;
            word_count <= '0;
            full       <= 1'b0;
          end else if (rst_cnt_q == RcW'(RST_CYCLES - 1)) begin
            state_q     <= StRun;
            cpu_reset_N <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (mode_s2_q) begin
            state_q     <= StProg;
            cpu_reset_N <= 1'b0;
            mem_addr    <= '0;
            word_count  <= '0;
            full        <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
